reverse_buf: RTL and testbench



---
 rtl/reverse_buf.sv | 102 ++++++++++
 tb/tb_reverse_buf.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reverse_buf.sv
// Reverse (skid) buffer: cuts the backward ready path with one skid register; valid/data pass straight through when empty.
// Latency 0 cycles when empty, 1+ when skidded; input_port_ready = ~skid_valid, so every stall costs one input bubble.

module reverse_buf_logic (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic skid_valid,
  output logic load_en
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (in_valid && !out_ready) state_d = FULL;
      FULL:    if (out_ready)              state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Capture only the beat that would otherwise be lost to a stall while empty.
  always_comb begin
    skid_valid = (state_q == FULL);
    load_en    = (state_q == EMPTY) && in_valid && !out_ready;
  end

endmodule

module reverse_buf #(
  parameter int DATA_WIDTH      = 8,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clock_port,
  input  logic                       reset_port,
  input  logic [DATA_WIDTH-1:0]      input_port_data,
  input  logic                       input_port_valid,
  output logic                       input_port_ready,
  output logic [DATA_WIDTH-1:0]      output_port_data,
  output logic                       output_port_valid,
  input  logic                       output_port_ready,
  input  logic                       stat_clear,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  logic                       skid_valid;
  logic                       load_en;
  logic                       stall;
  logic [DATA_WIDTH-1:0]      skid_data_q, skid_data_d;
  logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  reverse_buf_logic u_logic (
    .clk        (clock_port),
    .rst        (reset_port),
    .in_valid   (input_port_valid),
    .out_ready  (output_port_ready),
    .skid_valid (skid_valid),
    .load_en    (load_en)
  );

  // Ready comes straight off the state flop: no path from output_port_ready.
  always_comb begin
    input_port_ready  = !skid_valid;
    output_port_valid = skid_valid ? 1'b1 : input_port_valid;
    output_port_data  = skid_valid ? skid_data_q : input_port_data;
    stall             = output_port_valid && !output_port_ready;
    stall_count       = stall_count_q;
  end

  always_comb begin
    skid_data_d = skid_data_q;
    if (load_en) skid_data_d = input_port_data;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stat_clear)
      stall_count_d = '0;
    else if (stall && (stall_count_q != {STALL_CNT_WIDTH{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clock_port) begin
    if (reset_port) begin
      skid_data_q   <= '0;
      stall_count_q <= '0;
    end else begin
      skid_data_q   <= skid_data_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_reverse_buf.sv
// Self-checking bench for reverse_buf: directed scenarios plus randomized traffic against a queue-based reference model.

module tb_reverse_buf;

  logic       clk = 1'b0;
  logic       reset_port = 1'b1;
  logic [7:0] input_port_data = '0;
  logic       input_port_valid = 1'b0;
  logic       input_port_ready;
  logic [7:0] output_port_data;
  logic       output_port_valid;
  logic       output_port_ready = 1'b0;
  logic       stat_clear = 1'b0;
  logic [3:0] stall_count;

  reverse_buf #(.DATA_WIDTH(8), .STALL_CNT_WIDTH(4)) dut (
    .clock_port        (clk),
    .reset_port        (reset_port),
    .input_port_data   (input_port_data),
    .input_port_valid  (input_port_valid),
    .input_port_ready  (input_port_ready),
    .output_port_data  (output_port_data),
    .output_port_valid (output_port_valid),
    .output_port_ready (output_port_ready),
    .stat_clear        (stat_clear),
    .stall_count       (stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: beats held inside the buffer, beats accepted but not yet delivered, stall count.
  logic [7:0] held[$];
  logic [7:0] sent[$];
  int         m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic clr, input logic rst, output logic acc);
    logic       exp_rdy, exp_ov, obs_ov, r0;
    logic [7:0] exp_od, obs_od, exp_beat;
    @(negedge clk);
    input_port_valid  = iv;
    input_port_data   = id;
    output_port_ready = ordy;
    stat_clear        = clr;
    reset_port        = rst;
    #1;
    exp_rdy = (held.size() == 0);
    exp_ov  = (held.size() != 0) ? 1'b1 : iv;
    exp_od  = (held.size() != 0) ? held[0] : id;
    chk("in_rdy", input_port_ready, exp_rdy);
    chk("out_vld", output_port_valid, exp_ov);
    if (exp_ov) chk("out_dat", output_port_data, exp_od);
    chk("stall_cnt", stall_count, m_cnt);
    obs_ov = output_port_valid;
    obs_od = output_port_data;
    r0     = input_port_ready;
    output_port_ready = !ordy;
    #1;
    chk("rdy_indep", input_port_ready, r0);
    output_port_ready = ordy;
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      held.delete();
      sent.delete();
      m_cnt = 0;
    end else begin
      acc = iv && (held.size() == 0);
      if (acc) sent.push_back(id);
      if (obs_ov && ordy) begin
        if (sent.size() == 0) chk("extra_beat", 32'(sent.size()), 1);
        else begin
          exp_beat = sent.pop_front();
          chk("order", obs_od, exp_beat);
        end
      end
      if (held.size() != 0) begin
        if (ordy) void'(held.pop_front());
      end else if (iv && !ordy) begin
        held.push_back(id);
      end
      if (clr) m_cnt = 0;
      else if (exp_ov && !ordy && m_cnt < 15) m_cnt++;
    end
  endtask

  initial begin
    logic a;
    int   acc_total;
    int   cyc;
    logic [7:0] beat;

    repeat (2) @(posedge clk);
    cycle(0, 8'h00, 0, 0, 1, a);
    cycle(0, 8'h00, 0, 0, 0, a);

    // Pass-through at full rate
    cycle(1, 8'h11, 1, 0, 0, a);
    cycle(1, 8'h22, 1, 0, 0, a);
    cycle(1, 8'h33, 1, 0, 0, a);
    #1 chk("pt_cnt", stall_count, 0);

    // Single stall of 0xA5 for three cycles
    cycle(1, 8'hA5, 0, 0, 0, a);
    #1 chk("a5_rdy", input_port_ready, 0);
    chk("a5_hold", output_port_data, 8'hA5);
    cycle(0, 8'h00, 0, 0, 0, a);
    cycle(0, 8'h00, 0, 0, 0, a);
    cycle(0, 8'h00, 1, 0, 0, a);
    #1 chk("a5_rdy_back", input_port_ready, 1);
    chk("a5_cnt", stall_count, 3);

    // Drain and new input in the same cycle
    cycle(1, 8'h44, 0, 0, 0, a);
    cycle(1, 8'h77, 1, 0, 0, a);
    chk("77_not_acc", a, 0);
    cycle(1, 8'h77, 1, 0, 0, a);
    chk("77_acc", a, 1);

    // Saturation and clear during a stall
    cycle(0, 8'h00, 1, 1, 0, a);
    for (int i = 0; i < 20; i++) cycle(1, 8'hC3, 0, 0, 0, a);
    #1 chk("sat_cnt", stall_count, 15);
    cycle(0, 8'h00, 0, 1, 0, a);
    #1 chk("clr_cnt", stall_count, 0);
    cycle(0, 8'h00, 0, 0, 0, a);
    #1 chk("resume_cnt", stall_count, 1);
    cycle(0, 8'h00, 1, 0, 0, a);

    // Reset while holding 0x5A
    cycle(1, 8'h5A, 0, 0, 0, a);
    cycle(0, 8'h00, 0, 0, 1, a);
    #1 chk("rst_rdy", input_port_ready, 1);
    chk("rst_cnt", stall_count, 0);
    cycle(1, 8'h66, 1, 0, 0, a);
    cycle(0, 8'h00, 1, 0, 0, a);

    // Randomized traffic, incrementing payload
    acc_total = 0;
    cyc = 0;
    beat = 8'h00;
    while (acc_total < 1000 && cyc < 5000) begin
      cycle(1'($urandom_range(0, 1)), beat, 1'($urandom_range(0, 1)), 0, 0, a);
      if (a) begin
        beat++;
        acc_total++;
      end
      cyc++;
    end
    chk("rand_accepted", acc_total, 1000);
    cycle(0, 8'h00, 1, 0, 0, a);
    cycle(0, 8'h00, 1, 0, 0, a);
    chk("drained", 32'(sent.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
